// File: rtl/text_pixel_pipeline.sv
// Text-mode pixel pipeline: turns character-cell coordinates, a character code
// and its attribute byte into an RGB pixel. An external synchronous glyph ROM
// sits between stage 0 and stage 1. Colour, hsync and vsync leave exactly three
// clocks after they enter, and the pipeline never stalls.
module text_pixel_pipeline #(
  parameter int FONT_W       = 8,
  parameter int FONT_H       = 16,
  parameter int COLOR_W      = 8,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic [$clog2(FONT_W)-1:0]     px_col,
  input  logic [$clog2(FONT_H)-1:0]     px_row,
  input  logic [7:0]                    char_code,
  input  logic [7:0]                    char_attr,
  input  logic                          cursor_hit,
  output logic [8+$clog2(FONT_H)-1:0]   font_addr,
  input  logic [FONT_W-1:0]             font_row,
  input  logic                          pal_we,
  input  logic [3:0]                    pal_idx,
  input  logic [3*COLOR_W-1:0]          pal_data,
  output logic [COLOR_W-1:0]            r_out,
  output logic [COLOR_W-1:0]            g_out,
  output logic [COLOR_W-1:0]            b_out,
  output logic                          hsync_out,
  output logic                          vsync_out
);

  localparam int COL_W = $clog2(FONT_W);
  localparam int ROW_W = $clog2(FONT_H);
  localparam int RGB_W = 3 * COLOR_W;

  // Per-pixel side information that travels alongside the glyph fetch.
  typedef struct packed {
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       attr;
    logic             cursor;
  } side_t;

  side_t            s0_q;
  side_t            s1_q;
  logic [7:0]       frame_cnt_q;
  logic             blink_phase_q;
  logic [RGB_W-1:0] pal_q [16];

  logic             glyph_bit;
  logic             cursor_on;
  logic [3:0]       fg_idx;
  logic [3:0]       bg_idx;
  logic [3:0]       pal_rd_idx;
  logic [RGB_W-1:0] rgb_d;

  // Stage 0: register the raw inputs and present the glyph ROM address.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q      <= '0;
      font_addr <= '0;
    end else begin
      s0_q      <= '{hsync: hsync_in, vsync: vsync_in, blank: blank_in,
                     col: px_col, row: px_row, attr: char_attr,
                     cursor: cursor_hit};
      font_addr <= {char_code, px_row};
    end
  end

  // Stage 1: delay side information so it lines up with the returning ROM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s0_q;
    end
  end

  // Frame counter and blink phase, stepped on vsync rising edges only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (vsync_in && !s0_q.vsync) begin
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q   <= frame_cnt_q + 8'd1;
      end
    end
  end

  // Palette storage; entry 15 comes up white so text is visible before setup.
  // NOTE: this small array is built from flops, so it can be given a defined
  // reset state; a RAM-mapped memory would get no reset at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        pal_q[i] <= (i == 15) ? '1 : '0;
      end
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_data;
    end
  end

  // Stage 2: pick the glyph bit, apply blink and cursor, read the palette.
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    glyph_bit = 1'b0;
    for (int i = 0; i < FONT_W; i++) begin
      if (s1_q.col == COL_W'(i)) begin
        glyph_bit = font_row[FONT_W-1-i];
      end
    end
    fg_idx = s1_q.attr[3:0];
    bg_idx = {1'b0, s1_q.attr[6:4]};
    if (s1_q.attr[7] && blink_phase_q) begin
      fg_idx = bg_idx;
    end
    cursor_on  = s1_q.cursor && (s1_q.row >= ROW_W'(FONT_H - 2)) && !blink_phase_q;
    pal_rd_idx = (glyph_bit || cursor_on) ? fg_idx : bg_idx;
    // The palette is read before this edge's write lands, so a same-index
    // write shows up on the following pixel.
    rgb_d      = s1_q.blank ? '0 : pal_q[pal_rd_idx];
  end

  // Stage 3: register the colour and the syncs that go with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      r_out     <= rgb_d[RGB_W-1 -: COLOR_W];
      g_out     <= rgb_d[2*COLOR_W-1 -: COLOR_W];
      b_out     <= rgb_d[COLOR_W-1:0];
      hsync_out <= s1_q.hsync;
      vsync_out <= s1_q.vsync;
    end
  end

endmodule

// File: tb/tb_text_pixel_pipeline.sv
// Testbench for text_pixel_pipeline: a frame-level model predicts every output
// cycle by cycle, and directed scenarios pin key pixels to literal colours.
module tb_text_pixel_pipeline;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in, blank_in, cursor_hit, pal_we;
  logic [2:0]  px_col;
  logic [3:0]  px_row, pal_idx;
  logic [7:0]  char_code, char_attr;
  logic [11:0] font_addr;
  logic [7:0]  font_row;
  logic [23:0] pal_data;
  logic [7:0]  r_out, g_out, b_out;
  logic        hsync_out, vsync_out;

  int n_pass  = 0;
  int n_total = 0;

  text_pixel_pipeline #(
    .FONT_W(8), .FONT_H(16), .COLOR_W(8), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blank_in(blank_in), .px_col(px_col), .px_row(px_row),
    .char_code(char_code), .char_attr(char_attr), .cursor_hit(cursor_hit),
    .font_addr(font_addr), .font_row(font_row), .pal_we(pal_we),
    .pal_idx(pal_idx), .pal_data(pal_data), .r_out(r_out), .g_out(g_out),
    .b_out(b_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  always #5 clk = ~clk;

  // Glyph ROM contents: a simple reversible pattern of code and row.
  function automatic logic [7:0] rom_byte(input logic [7:0] code, input logic [3:0] row);
    return code ^ {row, 4'h0};
  endfunction

  // Synchronous glyph ROM with one cycle of latency.
  always @(posedge clk) font_row <= rom_byte(font_addr[11:4], font_addr[3:0]);

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [2:0] col;
    logic [3:0] row;
    logic [7:0] code;
    logic [7:0] attr;
    logic       cur;
  } smp_t;

  smp_t        cur_s, hist0, hist1;
  logic [23:0] mpal [16];
  int          edges;
  logic        mprev_vs;
  logic [23:0] exp_rgb;
  logic        exp_hs, exp_vs;

  assign cur_s = '{hs: hsync_in, vs: vsync_in, blank: blank_in, col: px_col,
                   row: px_row, code: char_code, attr: char_attr, cur: cursor_hit};

  // Colour a pixel from the text-mode rules, with the blink phase derived
  // from the number of vsync edges seen since reset.
  function automatic logic [23:0] pixel_colour(input smp_t s);
    logic [7:0] glyph;
    logic       lit, phase;
    logic [3:0] fg, bg, idx;
    glyph = rom_byte(s.code, s.row);
    lit   = glyph[7 - int'(s.col)];
    phase = ((edges / BF) % 2) == 1;
    fg    = s.attr[3:0];
    bg    = {1'b0, s.attr[6:4]};
    if (s.attr[7] && phase) fg = bg;
    idx   = lit ? fg : bg;
    if (s.cur && s.row >= 4'd14 && !phase) idx = fg;
    return s.blank ? 24'h0 : mpal[idx];
  endfunction

  // Reference model: output after edge n reflects the inputs sampled at n-2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0    <= '0;
      hist1    <= '0;
      edges    <= 0;
      mprev_vs <= 1'b0;
      exp_rgb  <= '0;
      exp_hs   <= 1'b0;
      exp_vs   <= 1'b0;
      for (int i = 0; i < 16; i++) mpal[i] <= (i == 15) ? 24'hFFFFFF : 24'h0;
    end else begin
      exp_rgb  <= pixel_colour(hist1);
      exp_hs   <= hist1.hs;
      exp_vs   <= hist1.vs;
      hist1    <= hist0;
      hist0    <= cur_s;
      if (pal_we) mpal[pal_idx] <= pal_data;
      if (vsync_in && !mprev_vs) edges <= edges + 1;
      mprev_vs <= vsync_in;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    check("model_rgb", {8'h0, r_out, g_out, b_out}, {8'h0, exp_rgb});
    check("model_hsync", {31'h0, hsync_out}, {31'h0, exp_hs});
    check("model_vsync", {31'h0, vsync_out}, {31'h0, exp_vs});
    check("model_font_addr", {20'h0, font_addr}, {20'h0, hist0.code, hist0.row});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic blank, input logic [7:0] code, input logic [3:0] row,
                       input logic [2:0] col, input logic [7:0] attr, input logic cur);
    blank_in   = blank;
    char_code  = code;
    px_row     = row;
    px_col     = col;
    char_attr  = attr;
    cursor_hit = cur;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    cycles(1);
    vsync_in = 1'b0;
  endtask

  function automatic logic [31:0] rgb();
    return {8'h0, r_out, g_out, b_out};
  endfunction

  initial begin
    rst_n = 1'b0;
    hsync_in = 0; vsync_in = 0; pal_we = 0; pal_idx = 0; pal_data = 0;
    drive(1'b0, 8'h00, 4'h0, 3'h0, 8'h00, 1'b0);
    cycles(3);
    check("reset_rgb", rgb(), 32'h0);
    check("reset_font_addr", {20'h0, font_addr}, 32'h0);
    rst_n = 1'b1;

    // Glyph pixel: MSB lit -> palette[15]; next column unlit -> palette[0].
    drive(1'b0, 8'h80, 4'h0, 3'h0, 8'h0F, 1'b0);
    cycles(3);
    check("glyph_col0", rgb(), 32'hFFFFFF);
    drive(1'b0, 8'h80, 4'h0, 3'h1, 8'h0F, 1'b0);
    cycles(3);
    check("glyph_col1", rgb(), 32'h0);

    // Palette write coinciding with the read of the first pixel.
    drive(1'b0, 8'h80, 4'h0, 3'h0, 8'h03, 1'b0);
    cycles(2);
    pal_we = 1; pal_idx = 4'd3; pal_data = 24'h123456;
    cycles(1);
    pal_we = 0;
    check("pal_old_value", rgb(), 32'h0);
    cycles(1);
    check("pal_new_value", rgb(), 32'h123456);

    // Blink with BLINK_FRAMES=2: phase toggles every second vsync edge.
    drive(1'b0, 8'h80, 4'h0, 3'h0, 8'h8F, 1'b0);
    cycles(4);
    check("blink_p0", rgb(), 32'hFFFFFF);
    for (int p = 1; p <= 4; p++) begin
      vsync_pulse();
      cycles(5);
      check($sformatf("blink_edge%0d", p), rgb(), ((p / 2) % 2 == 1) ? 32'h0 : 32'hFFFFFF);
    end

    // Cursor on the last glyph row with an empty glyph.
    drive(1'b0, 8'hF0, 4'hF, 3'h0, 8'h3F, 1'b1);
    cycles(4);
    check("cursor_phase0", rgb(), 32'hFFFFFF);
    vsync_pulse(); cycles(2); vsync_pulse(); cycles(5);
    check("cursor_phase1", rgb(), 32'h123456);

    // Sync latency: single-cycle pulses appear exactly three cycles later.
    drive(1'b1, 8'h00, 4'h0, 3'h0, 8'h00, 1'b0);
    cycles(4);
    hsync_in = 1; cycles(1); hsync_in = 0;
    cycles(1); check("hsync_lat2", {31'h0, hsync_out}, 32'h0);
    cycles(1); check("hsync_lat3", {31'h0, hsync_out}, 32'h1);
    cycles(1); check("hsync_lat4", {31'h0, hsync_out}, 32'h0);
    vsync_in = 1; cycles(1); vsync_in = 0;
    cycles(1); check("vsync_lat2", {31'h0, vsync_out}, 32'h0);
    cycles(1); check("vsync_lat3", {31'h0, vsync_out}, 32'h1);
    cycles(1); check("vsync_lat4", {31'h0, vsync_out}, 32'h0);

    // Blanking wins over a lit glyph.
    drive(1'b1, 8'h80, 4'h0, 3'h0, 8'h0F, 1'b0);
    cycles(4);
    check("blank_lit", rgb(), 32'h0);

    // Mid-frame reset clears outputs at once and returns blink phase to 0.
    drive(1'b0, 8'hF0, 4'hF, 3'h0, 8'h3F, 1'b1);
    cycles(4);
    check("pre_reset_cursor", rgb(), 32'h123456);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rgb", rgb(), 32'h0);
    check("async_reset_addr", {20'h0, font_addr}, 32'h0);
    cycles(1);
    rst_n = 1'b1;
    cycles(4);
    check("post_reset_cursor", rgb(), 32'hFFFFFF);

    // Fill the palette, then sweep a mix of glyphs, attributes and syncs.
    blank_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      pal_we = 1; pal_idx = 4'(i); pal_data = 24'(i * 24'h111111) ^ 24'h0A0B0C;
      cycles(1);
    end
    pal_we = 0;
    for (int i = 0; i < 40; i++) begin
      drive((i % 7) == 3, 8'(i * 37 + 5), 4'(i % 16), 3'(i * 3), 8'(i * 53), (i % 5) == 0);
      hsync_in = (i % 6) == 1;
      vsync_in = (i % 9) == 0;
      cycles(1);
    end
    hsync_in = 0; vsync_in = 0;
    cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
